// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers build the window, 4-stage pipeline to edge_out.
// Optional per-frame edge statistics are enabled by defining SOBEL_STATS_EN.
module sobel_stream #(
   parameter int PIX_W     = 8,
   parameter int LINE_W    = 640,
   parameter int MAG_SHIFT = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [PIX_W-1:0]   pix_in,
   input  logic               pix_valid,
   input  logic               sof,
   input  logic               mode,
   input  logic [PIX_W+2:0]   thresh,
   output logic [PIX_W-1:0]   edge_out,
   output logic               edge_valid
`ifdef SOBEL_STATS_EN
   ,
   output logic [31:0]        edge_count,
   output logic               count_valid
`endif
);

   localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam int GW    = PIX_W + 3;
   localparam int AW    = PIX_W + 2;

   logic [COL_W-1:0]        col_r, cur_col_s, next_col_s;
   logic [1:0]              row_r, cur_row_s, next_row_s;
   logic                    border_s;
   logic [PIX_W-1:0]        lb0_r [LINE_W];
   logic [PIX_W-1:0]        lb1_r [LINE_W];
   logic [PIX_W-1:0]        lb0_rd_s, lb1_rd_s;
   logic [PIX_W-1:0]        z_r   [9];
   logic                    v0_r, b0_r;
   logic [PIX_W-1:0]        win_r [9];
   logic                    s1_valid_r, s1_border_r;
   logic signed [GW-1:0]    gx_s, gy_s, gx_r, gy_r;
   logic                    s2_valid_r, s2_border_r;
   logic [AW-1:0]           ax_r, ay_r;
   logic                    s3_valid_r, s3_border_r;
   logic [GW-1:0]           sum_s, shifted_s;
   logic [PIX_W-1:0]        edge_next_s;

   function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
      return $signed({3'b000, p});
   endfunction

   function automatic logic [AW-1:0] mag(input logic signed [GW-1:0] g);
      logic signed [GW-1:0] n;
      n = -g;
      return g[GW-1] ? AW'(n) : AW'(g);
   endfunction

   // Position of the current beat; sof forces it to (0,0) wherever the counters were.
   always_comb begin
      cur_col_s  = col_r;
      cur_row_s  = row_r;
      next_col_s = col_r;
      next_row_s = row_r;
      if (sof) begin
         cur_col_s = '0;
         cur_row_s = 2'd0;
      end else begin
         cur_col_s = col_r;
         cur_row_s = row_r;
      end
      if (cur_col_s == COL_W'(LINE_W - 1)) begin
         next_col_s = '0;
         next_row_s = (cur_row_s == 2'd2) ? 2'd2 : cur_row_s + 2'd1;
      end else begin
         next_col_s = cur_col_s + COL_W'(1);
         next_row_s = cur_row_s;
      end
      border_s = (cur_row_s < 2'd2) | (cur_col_s < COL_W'(2));
      lb0_rd_s = lb0_r[cur_col_s];
      lb1_rd_s = lb1_r[cur_col_s];
   end

   // Column/row counters advance on accepted beats only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col_r <= '0;
         row_r <= 2'd0;
      end else if (pix_valid) begin
         col_r <= next_col_s;
         row_r <= next_row_s;
      end
   end

   // Line buffers, read-before-write: lb0 keeps the previous row, lb1 the one before.
   always_ff @(posedge clock) begin
      if (pix_valid) begin
         lb0_r[cur_col_s] <= pix_in;
         lb1_r[cur_col_s] <= lb0_rd_s;
      end
   end

   // Window column shift registers plus the valid/border tag of the beat that just shifted in.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 9; i++) z_r[i] <= '0;
         v0_r <= 1'b0;
         b0_r <= 1'b0;
      end else begin
         v0_r <= pix_valid;
         if (pix_valid) begin
            b0_r   <= border_s;
            z_r[0] <= z_r[1]; z_r[1] <= z_r[2]; z_r[2] <= lb1_rd_s;
            z_r[3] <= z_r[4]; z_r[4] <= z_r[5]; z_r[5] <= lb0_rd_s;
            z_r[6] <= z_r[7]; z_r[7] <= z_r[8]; z_r[8] <= pix_in;
         end
      end
   end

   // Gradients of the captured window; worst case +-4*(2^PIX_W-1) fits PIX_W+3 signed bits.
   always_comb begin
      gx_s = (ext(win_r[2]) - ext(win_r[0])) + (ext(win_r[5]) - ext(win_r[3]))
           + (ext(win_r[5]) - ext(win_r[3])) + (ext(win_r[8]) - ext(win_r[6]));
      gy_s = (ext(win_r[0]) - ext(win_r[6])) + (ext(win_r[1]) - ext(win_r[7]))
           + (ext(win_r[1]) - ext(win_r[7])) + (ext(win_r[2]) - ext(win_r[8]));
   end

   // Stages S1..S3: window capture, gradients, absolute values; bubbles carry valid=0.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 9; i++) win_r[i] <= '0;
         s1_valid_r  <= 1'b0;
         s1_border_r <= 1'b0;
         gx_r        <= '0;
         gy_r        <= '0;
         s2_valid_r  <= 1'b0;
         s2_border_r <= 1'b0;
         ax_r        <= '0;
         ay_r        <= '0;
         s3_valid_r  <= 1'b0;
         s3_border_r <= 1'b0;
      end else begin
         win_r       <= z_r;
         s1_valid_r  <= v0_r;
         s1_border_r <= b0_r;
         gx_r        <= gx_s;
         gy_r        <= gy_s;
         s2_valid_r  <= s1_valid_r;
         s2_border_r <= s1_border_r;
         ax_r        <= mag(gx_r);
         ay_r        <= mag(gy_r);
         s3_valid_r  <= s2_valid_r;
         s3_border_r <= s2_border_r;
      end
   end

   // S4 output selection; mode and thresh are taken live here so in-flight beats see the new value.
   always_comb begin
      sum_s       = GW'(ax_r) + GW'(ay_r);
      shifted_s   = sum_s >> MAG_SHIFT;
      edge_next_s = '0;
      if (s3_border_r) begin
         edge_next_s = '0;
      end else if (mode) begin
         if (|shifted_s[GW-1:PIX_W]) begin
            edge_next_s = '1;
         end else begin
            edge_next_s = shifted_s[PIX_W-1:0];
         end
      end else if (sum_s > thresh) begin
         edge_next_s = '1;
      end else begin
         edge_next_s = '0;
      end
   end

   // Registered edge output.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         edge_out   <= '0;
         edge_valid <= 1'b0;
      end else begin
         edge_valid <= s3_valid_r;
         edge_out   <= s3_valid_r ? edge_next_s : '0;
      end
   end

`ifdef SOBEL_STATS_EN
   logic [31:0] cnt_r;
   logic        hit_s;

   assign hit_s = s3_valid_r & ~s3_border_r & (sum_s > thresh);

   // Per-frame edge counter; a hit coinciding with sof belongs to the new frame.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_r       <= 32'd0;
         edge_count  <= 32'd0;
         count_valid <= 1'b0;
      end else begin
         count_valid <= 1'b0;
         if (pix_valid & sof) begin
            edge_count  <= cnt_r;
            count_valid <= 1'b1;
            cnt_r       <= hit_s ? 32'd1 : 32'd0;
         end else if (hit_s) begin
            cnt_r <= cnt_r + 32'd1;
         end
      end
   end
`endif

endmodule
